// File: rtl/sound_tone_ctrl_pkg.sv
// Shared definitions for the tone-select controller: code widths, FSM states,
// and helpers for the one-hot mute decode and the per-code tone select.
package sound_tone_ctrl_pkg;

    localparam int unsigned TONE_CODE_W = 3;
    localparam int unsigned NUM_TONES   = 7;
    localparam int unsigned CNT_W       = 16;

    typedef logic [TONE_CODE_W-1:0] tone_code_t;
    typedef logic [NUM_TONES-1:0]   tone_mask_t;

    localparam tone_code_t SILENCE  = '0;
    localparam tone_mask_t MUTE_ALL = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    // All generators muted except the one selected by code (code 0 mutes all).
    function automatic tone_mask_t mute_mask(input tone_code_t code);
        tone_mask_t m;
        for (int unsigned i = 0; i < NUM_TONES; i++) begin
            m[i] = (code != TONE_CODE_W'(i + 1));
        end
        return m;
    endfunction

    // Output of the generator selected by code; 0 for the silence code.
    function automatic logic tone_bit(input tone_mask_t tones, input tone_code_t code);
        logic b;
        b = 1'b0;
        for (int unsigned i = 0; i < NUM_TONES; i++) begin
            if (code == TONE_CODE_W'(i + 1)) b = tones[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sound_tone_ctrl.sv
// Tone-select controller: mutes all but the selected generator, muxes its output,
// and switches tones only after the current high pulse ends plus a silent gap.
module sound_tone_ctrl
    import sound_tone_ctrl_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 50,
    parameter int unsigned DRAIN_MAX  = 16383
) (
    input  logic                   clk_50M,
    input  logic                   reset_n,
    input  logic                   wr,
    input  logic [TONE_CODE_W-1:0] wr_data,
    input  logic [NUM_TONES-1:0]   tone_in,
    output logic [NUM_TONES-1:0]   tone_off,
    output logic                   audio_out,
    output logic [TONE_CODE_W-1:0] cur_tone,
    output logic                   busy
);

    state_t           state, state_nxt;
    tone_code_t       cur, cur_nxt;
    tone_code_t       pending, pending_nxt;
    logic [CNT_W-1:0] counter, counter_nxt;
    tone_mask_t       tone_off_nxt;
    logic             audio_nxt;
    tone_code_t       cur_tone_nxt;
    logic             busy_nxt;
    tone_code_t       dest;
    logic             cur_bit;

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur       <= SILENCE;
            pending   <= SILENCE;
            counter   <= '0;
            tone_off  <= MUTE_ALL;
            audio_out <= 1'b0;
            cur_tone  <= SILENCE;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            pending   <= pending_nxt;
            counter   <= counter_nxt;
            tone_off  <= tone_off_nxt;
            audio_out <= audio_nxt;
            cur_tone  <= cur_tone_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur;
        pending_nxt  = pending;
        counter_nxt  = counter;
        tone_off_nxt = tone_off;
        audio_nxt    = 1'b0;
        cur_tone_nxt = cur_tone;
        busy_nxt     = busy;
        // A write landing on the gap's last clock overrides the stored destination.
        dest         = wr ? wr_data : pending;
        cur_bit      = tone_bit(tone_in, cur);

        unique case (state)
            IDLE: begin
                tone_off_nxt = MUTE_ALL;
                cur_tone_nxt = SILENCE;
                busy_nxt     = 1'b0;
                if (wr && (wr_data != SILENCE)) begin
                    state_nxt    = PLAY;
                    cur_nxt      = wr_data;
                    cur_tone_nxt = wr_data;
                    tone_off_nxt = mute_mask(wr_data);
                end
            end
            PLAY: begin
                audio_nxt = cur_bit;
                if (wr && (wr_data != cur)) begin
                    state_nxt   = DRAIN;
                    pending_nxt = wr_data;
                    counter_nxt = CNT_W'(DRAIN_MAX);
                    busy_nxt    = 1'b1;
                end
            end
            DRAIN: begin
                if (wr) pending_nxt = wr_data;
                if (!cur_bit || (counter == '0)) begin
                    state_nxt    = GAP;
                    tone_off_nxt = MUTE_ALL;
                    cur_tone_nxt = SILENCE;
                    counter_nxt  = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    audio_nxt   = cur_bit;
                    counter_nxt = counter - CNT_W'(1);
                end
            end
            GAP: begin
                if (wr) pending_nxt = wr_data;
                if (counter == '0) begin
                    busy_nxt    = 1'b0;
                    pending_nxt = SILENCE;
                    if (dest == SILENCE) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt    = PLAY;
                        cur_nxt      = dest;
                        cur_tone_nxt = dest;
                        tone_off_nxt = mute_mask(dest);
                    end
                end else begin
                    counter_nxt = counter - CNT_W'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sound_tone_ctrl.sv
// Bench for sound_tone_ctrl: directed scenarios then random traffic, all
// checked every clock against a time-remaining model of the tone controller.
module tb_sound_tone_ctrl;

    localparam int GAP  = 50;
    localparam int DMAX = 16383;

    logic       clk_50M;
    logic       reset_n;
    logic       wr;
    logic [2:0] wr_data;
    logic [6:0] tone_in;
    logic [6:0] tone_off;
    logic       audio_out;
    logic [2:0] cur_tone;
    logic       busy;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference: sounding code, queued destination (-1 none), drain clocks used, gap clocks left.
    int   m_code       = 0;
    int   m_target     = -1;
    int   m_drain_used = 0;
    int   m_gap_left   = 0;
    logic m_audio      = 1'b0;

    sound_tone_ctrl #(.GAP_CYCLES(GAP), .DRAIN_MAX(DMAX)) dut (
        .clk_50M  (clk_50M),
        .reset_n  (reset_n),
        .wr       (wr),
        .wr_data  (wr_data),
        .tone_in  (tone_in),
        .tone_off (tone_off),
        .audio_out(audio_out),
        .cur_tone (cur_tone),
        .busy     (busy)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    function automatic logic [6:0] exp_mask(input int code);
        logic [6:0] one;
        one = 7'd1;
        if (code == 0) return 7'h7F;
        return 7'h7F & ~(one << (code - 1));
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_code = 0; m_target = -1; m_drain_used = 0; m_gap_left = 0; m_audio = 1'b0;
    endtask

    task automatic model_edge(input logic w, input int d);
        if (m_gap_left > 0) begin
            if (w) m_target = d;
            m_gap_left--;
            m_audio = 1'b0;
            if (m_gap_left == 0) begin
                m_code   = m_target;
                m_target = -1;
            end
        end else if (m_target >= 0) begin
            if (w) m_target = d;
            if (tone_in[m_code-1] == 1'b0 || m_drain_used == DMAX) begin
                m_code     = 0;
                m_gap_left = GAP;
                m_audio    = 1'b0;
            end else begin
                m_drain_used++;
                m_audio = 1'b1;
            end
        end else if (m_code != 0) begin
            m_audio = tone_in[m_code-1];
            if (w && d != m_code) begin
                m_target     = d;
                m_drain_used = 0;
            end
        end else begin
            m_audio = 1'b0;
            if (w && d != 0) m_code = d;
        end
    endtask

    task automatic check_model();
        check("tone_off",  8'(tone_off),  8'(exp_mask(m_code)));
        check("audio_out", 8'(audio_out), 8'(m_audio));
        check("cur_tone",  8'(cur_tone),  8'(m_code));
        check("busy",      8'(busy),      8'(m_target >= 0));
    endtask

    // One clock with the given write; outputs checked 1 time unit after the edge.
    task automatic step(input logic w, input logic [2:0] d);
        wr = w;
        wr_data = d;
        model_edge(w, int'(d));
        @(posedge clk_50M);
        #1;
        check_model();
        wr = 1'b0;
        wr_data = 3'd0;
    endtask

    // Clocks until the mute vector leaves all-muted; 0 if it never does within the bound.
    task automatic wait_gap_end(output int len);
        len = 0;
        for (int i = 1; i <= 200; i++) begin
            step(1'b0, 3'd0);
            if (tone_off != 7'h7F) begin
                len = i;
                break;
            end
        end
    endtask

    initial begin
        int         len;
        logic       prev;
        logic [5:0] pat;

        reset_n = 1'b0; wr = 1'b0; wr_data = 3'd0; tone_in = 7'd0;
        model_reset();
        #25;
        check("rst_tone_off", 8'(tone_off), 8'h7F);
        check("rst_audio",    8'(audio_out), 8'h0);
        check("rst_cur_tone", 8'(cur_tone), 8'h0);
        check("rst_busy",     8'(busy), 8'h0);
        @(negedge clk_50M);
        reset_n = 1'b1;

        // 1: asynchronous reset in the middle of PLAY code 3
        tone_in = 7'b0000100;
        step(1'b1, 3'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0);
        check("play3_audio", 8'(audio_out), 8'h1);
        #5 reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_tone_off", 8'(tone_off), 8'h7F);
        check("async_rst_audio",    8'(audio_out), 8'h0);
        @(negedge clk_50M);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tone_in = 7'($urandom);
            step(1'b0, 3'd0);
        end
        check("idle_after_rst", 8'(cur_tone), 8'h0);

        // 2: IDLE write of code 2, audio follows tone_in[1] one clock late
        tone_in = 7'd0;
        step(1'b1, 3'd2);
        check("start2_tone_off", 8'(tone_off), 8'(7'b1111101));
        check("start2_cur_tone", 8'(cur_tone), 8'd2);
        pat = 6'b101100;
        for (int i = 0; i < 6; i++) begin
            tone_in = {5'b10101, pat[i], 1'b1};
            prev = tone_in[1];
            step(1'b0, 3'd0);
            check("follow_audio", 8'(audio_out), 8'(prev));
        end

        // 3: switch 2 -> 5 waits for the high pulse to end, then 50-clock gap
        tone_in = 7'b0000010;
        step(1'b1, 3'd5);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0);
            check("drain_busy",     8'(busy), 8'h1);
            check("drain_tone_off", 8'(tone_off), 8'(7'b1111101));
        end
        tone_in = 7'b0000000;
        step(1'b0, 3'd0);
        check("drain_exit_tone_off", 8'(tone_off), 8'h7F);
        wait_gap_end(len);
        check("gap_len_5", 8'(len), 8'(GAP));
        check("play5_tone_off", 8'(tone_off), 8'(7'b1101111));
        check("play5_cur_tone", 8'(cur_tone), 8'd5);

        // 4: move to code 4, then a switch with tone_in[3] stuck high is forced by timeout
        step(1'b1, 3'd4);
        step(1'b0, 3'd0);
        wait_gap_end(len);
        check("play4_cur_tone", 8'(cur_tone), 8'd4);
        tone_in = 7'b0001000;
        step(1'b1, 3'd1);
        len = 0;
        for (int i = 1; i <= 20000; i++) begin
            step(1'b0, 3'd0);
            if (tone_off == 7'h7F) begin
                len = i;
                break;
            end
        end
        // Counter is loaded with DRAIN_MAX and the exit is taken on the clock it reads 0.
        check("forced_drain_len", 8'(len == DMAX + 1), 8'h1);
        wait_gap_end(len);
        check("gap_len_1", 8'(len), 8'(GAP));
        check("play1_cur_tone", 8'(cur_tone), 8'd1);

        // 5: writes of 0 then 7 during the gap neither extend it nor lose the last one
        tone_in = 7'b0000000;
        step(1'b1, 3'd6);
        step(1'b0, 3'd0);
        len = 0;
        for (int i = 1; i <= 200; i++) begin
            if (i == 10)      step(1'b1, 3'd0);
            else if (i == 20) step(1'b1, 3'd7);
            else              step(1'b0, 3'd0);
            if (tone_off != 7'h7F) begin
                len = i;
                break;
            end
        end
        check("gap_len_7", 8'(len), 8'(GAP));
        check("play7_cur_tone", 8'(cur_tone), 8'd7);
        check("play7_tone_off", 8'(tone_off), 8'(7'b0111111));

        // 6: rewrite of the current code is ignored; code 0 ends in IDLE
        step(1'b1, 3'd3);
        step(1'b0, 3'd0);
        wait_gap_end(len);
        check("play3_cur_tone", 8'(cur_tone), 8'd3);
        tone_in = 7'b0000100;
        step(1'b1, 3'd3);
        for (int i = 0; i < 3; i++) begin
            check("same_code_busy", 8'(busy), 8'h0);
            check("same_code_tone_off", 8'(tone_off), 8'(7'b1111011));
            step(1'b0, 3'd0);
        end
        step(1'b1, 3'd0);
        step(1'b0, 3'd0);
        tone_in = 7'b0000000;
        for (int i = 0; i < 200 && busy; i++) step(1'b0, 3'd0);
        check("silence_busy",     8'(busy), 8'h0);
        check("silence_cur_tone", 8'(cur_tone), 8'h0);
        check("silence_audio",    8'(audio_out), 8'h0);
        check("silence_tone_off", 8'(tone_off), 8'h7F);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) tone_in = 7'($urandom);
            step(($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
